// File: rtl/riscv_memory_pkg.sv
// Shared definitions for the memory stage: data width, funct3 and
// result-select encodings, access sizes, FSM states and address helpers.
package riscv_memory_pkg;

    localparam int unsigned XLEN = 32;

    // Load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size carried in funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Write-back result select
    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_LOAD = 2'd1;
    localparam logic [1:0] RES_PC4  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Clear the address bits below the natural alignment of the access size
    function automatic logic [XLEN-1:0] align_addr(input logic [1:0] size,
                                                   input logic [XLEN-1:0] addr);
        case (size)
            SZ_H:    return {addr[XLEN-1:1], 1'b0};
            SZ_W:    return {addr[XLEN-1:2], 2'b00};
            default: return addr;
        endcase
    endfunction

    // True when a halfword or word access is not naturally aligned
    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [1:0] offset);
        return ((size == SZ_H) && offset[0]) ||
               ((size == SZ_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_memory_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module riscv_lsu_align
    import riscv_memory_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] bus_rdata,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted;

    // Replicate store data across lanes and pick byte enables by size/offset
    always_comb begin
        bus_wdata = store_data;
        bus_be    = 4'b1111;
        case (funct3[1:0])
            SZ_B: begin
                bus_wdata = {4{store_data[7:0]}};
                bus_be    = 4'b0001 << offset;
            end
            SZ_H: begin
                bus_wdata = {2{store_data[15:0]}};
                bus_be    = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign shifted = bus_rdata >> {offset, 3'b000};

    // Extract the addressed lane and sign- or zero-extend it
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_W:    load_data = bus_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_memory.sv
// Pipeline memory stage: data-bus request/response FSM with timeout abort,
// stall generation and the M/W pipeline register.
// Optional build macro RISCV_MEM_MISALIGN_CHK_EN: misaligned half/word
// accesses are trapped locally instead of being issued with the address
// rounded down to the access size.
module riscv_memory
    import riscv_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid_m,
    input  logic            i_reg_write_m,
    input  logic [1:0]      i_result_src_m,
    input  logic            i_mem_write_m,
    input  logic            i_mem_read_m,
    input  logic [2:0]      i_funct3_m,
    input  logic [XLEN-1:0] i_alu_result_m,
    input  logic [XLEN-1:0] i_write_data_m,
    input  logic [4:0]      i_rd_m,
    input  logic [XLEN-1:0] i_pc_plus_4m,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [XLEN-1:0] o_dbus_wdata,
    output logic [3:0]      o_dbus_be,
    input  logic            i_dbus_gnt,
    input  logic            i_dbus_rvalid,
    input  logic [XLEN-1:0] i_dbus_rdata,
    input  logic            i_dbus_err,
    output logic            o_stall_m,
    output logic            o_valid_w,
    output logic            o_reg_write_w,
    output logic [1:0]      o_result_src_w,
    output logic [XLEN-1:0] o_alu_result_w,
    output logic [XLEN-1:0] o_read_data_w,
    output logic [4:0]      o_rd_w,
    output logic [XLEN-1:0] o_pc_plus_4w,
    output logic            o_bus_err_w,
    output logic            o_misalign_w
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            mem_op;
    logic            misaligned;
    logic            bus_op;
    logic            timeout;
    logic            complete;
    logic            err;
    logic [XLEN-1:0] load_data;

    assign mem_op = i_valid_m & (i_mem_read_m | i_mem_write_m);

`ifdef RISCV_MEM_MISALIGN_CHK_EN
    assign misaligned = mem_op & size_misaligned(i_funct3_m[1:0], i_alu_result_m[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign bus_op      = mem_op & ~misaligned;
    assign o_dbus_we   = i_mem_write_m;
    assign o_dbus_addr = align_addr(i_funct3_m[1:0], i_alu_result_m);

    riscv_lsu_align u_align (
        .funct3     (i_funct3_m),
        .offset     (o_dbus_addr[1:0]),
        .store_data (i_write_data_m),
        .bus_rdata  (i_dbus_rdata),
        .bus_wdata  (o_dbus_wdata),
        .bus_be     (o_dbus_be),
        .load_data  (load_data)
    );

    // Bus request, stall and completion qualifiers for the current cycle
    always_comb begin
        timeout    = (state != ST_IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        o_dbus_req = 1'b0;
        o_stall_m  = 1'b0;
        complete   = 1'b0;
        err        = 1'b1;
        case (state)
            ST_IDLE: begin
                o_dbus_req = bus_op;
                o_stall_m  = bus_op;
            end
            ST_REQ: begin
                o_dbus_req = ~timeout;
                o_stall_m  = ~timeout;
                complete   = timeout;
            end
            ST_RESP: begin
                o_stall_m = ~(i_dbus_rvalid | timeout);
                complete  = i_dbus_rvalid | timeout;
                err       = i_dbus_rvalid ? i_dbus_err : 1'b1;
            end
            default: ;
        endcase
    end

    // Access FSM and progress timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_op) begin
                        cnt   <= '0;
                        state <= i_dbus_gnt ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (timeout) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (i_dbus_gnt) state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (complete) state <= ST_IDLE;
                    else          cnt   <= cnt + CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // M/W register: pass-through, bus completion, or bubble while stalled
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == ST_IDLE ? bus_op : !complete)) begin
            o_valid_w      <= 1'b0;
            o_reg_write_w  <= 1'b0;
            o_result_src_w <= '0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_rd_w         <= '0;
            o_pc_plus_4w   <= '0;
            o_bus_err_w    <= 1'b0;
            o_misalign_w   <= 1'b0;
        end else begin
            o_valid_w      <= complete | i_valid_m;
            o_result_src_w <= i_result_src_m;
            o_alu_result_w <= i_alu_result_m;
            o_rd_w         <= i_rd_m;
            o_pc_plus_4w   <= i_pc_plus_4m;
            if (complete) begin
                o_reg_write_w <= i_reg_write_m & ~err;
                o_read_data_w <= load_data;
                o_bus_err_w   <= err;
                o_misalign_w  <= 1'b0;
            end else begin
                o_reg_write_w <= i_valid_m & i_reg_write_m & ~misaligned;
                o_read_data_w <= '0;
                o_bus_err_w   <= 1'b0;
                o_misalign_w  <= misaligned;
            end
        end
    end

endmodule

// File: tb/tb_riscv_memory.sv
// Directed bench for riscv_memory: vector table for single accesses plus
// hand-written sequences for wait states, timeout, bus error and reset.
module tb_riscv_memory;
    import riscv_memory_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, reg_write_m, mem_write_m, mem_read_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus_4m;
    logic [4:0]  rd_m;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        stall_m, valid_w, reg_write_w, bus_err_w, misalign_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus_4w;
    logic [4:0]  rd_w;

    int total = 0;
    int bad   = 0;

    riscv_memory #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid_m(valid_m), .i_reg_write_m(reg_write_m), .i_result_src_m(result_src_m),
        .i_mem_write_m(mem_write_m), .i_mem_read_m(mem_read_m), .i_funct3_m(funct3_m),
        .i_alu_result_m(alu_result_m), .i_write_data_m(write_data_m), .i_rd_m(rd_m),
        .i_pc_plus_4m(pc_plus_4m),
        .o_dbus_req(dbus_req), .o_dbus_we(dbus_we), .o_dbus_addr(dbus_addr),
        .o_dbus_wdata(dbus_wdata), .o_dbus_be(dbus_be),
        .i_dbus_gnt(dbus_gnt), .i_dbus_rvalid(dbus_rvalid), .i_dbus_rdata(dbus_rdata),
        .i_dbus_err(dbus_err),
        .o_stall_m(stall_m),
        .o_valid_w(valid_w), .o_reg_write_w(reg_write_w), .o_result_src_w(result_src_w),
        .o_alu_result_w(alu_result_w), .o_read_data_w(read_data_w), .o_rd_w(rd_w),
        .o_pc_plus_4w(pc_plus_4w), .o_bus_err_w(bus_err_w), .o_misalign_w(misalign_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw;
        logic [1:0]  res;
        logic        mw, mr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic [4:0]  rd;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_addr, exp_rdata;
        logic        exp_valid_w, exp_regw;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic valid, logic rw, logic [1:0] res, logic mw, logic mr,
                                logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic [4:0] rd, logic exp_req,
                                logic [3:0] exp_be, logic [31:0] exp_wdata,
                                logic [31:0] exp_addr, logic [31:0] exp_rdata,
                                logic exp_valid_w, logic exp_regw);
        vec_t v;
        v.valid = valid; v.rw = rw; v.res = res; v.mw = mw; v.mr = mr; v.f3 = f3;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_addr = exp_addr; v.exp_rdata = exp_rdata;
        v.exp_valid_w = exp_valid_w; v.exp_regw = exp_regw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_m = 0; reg_write_m = 0; result_src_m = RES_ALU; mem_write_m = 0;
        mem_read_m = 0; funct3_m = F3_W; alu_result_m = 0; write_data_m = 0;
        rd_m = 0; pc_plus_4m = 0; dbus_gnt = 0; dbus_rvalid = 0;
        dbus_rdata = 0; dbus_err = 0;
    endtask

    task automatic drive_op(input logic rw, input logic [1:0] res, input logic mw,
                            input logic mr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        valid_m = 1; reg_write_m = rw; result_src_m = res; mem_write_m = mw;
        mem_read_m = mr; funct3_m = f3; alu_result_m = addr; write_data_m = wdata;
        rd_m = rd; pc_plus_4m = addr + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int found;
        vec_t v;

        //          valid rw res      mw mr f3     addr          wdata         rdata         rd  req be       exp_wdata     exp_addr      exp_rdata     vw rw
        vecs[0]  = mk(1, 1, RES_ALU,  0, 0, F3_W,  32'h10,       32'h0,        32'h0,        5,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1);
        vecs[1]  = mk(0, 1, RES_ALU,  0, 0, F3_W,  32'h55,       32'h0,        32'h0,        7,  0, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(1, 1, RES_PC4,  0, 0, F3_W,  32'hDEADBEEF, 32'h0,        32'h0,        31, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1);
        vecs[3]  = mk(1, 0, RES_ALU,  1, 0, F3_B,  32'h101,      32'hAB,       32'h0,        0,  1, 4'b0010, 32'hABABABAB, 32'h101,      32'h0,        1, 0);
        vecs[4]  = mk(1, 0, RES_ALU,  1, 0, F3_B,  32'h103,      32'h1FF,      32'h0,        0,  1, 4'b1000, 32'hFFFFFFFF, 32'h103,      32'h0,        1, 0);
        vecs[5]  = mk(1, 0, RES_ALU,  1, 0, F3_H,  32'h200,      32'hCAFE,     32'h0,        0,  1, 4'b0011, 32'hCAFECAFE, 32'h200,      32'h0,        1, 0);
        vecs[6]  = mk(1, 0, RES_ALU,  1, 0, F3_W,  32'h300,      32'h12345678, 32'h0,        0,  1, 4'b1111, 32'h12345678, 32'h300,      32'h0,        1, 0);
        vecs[7]  = mk(1, 1, RES_LOAD, 0, 1, F3_B,  32'h103,      32'h0,        32'h80FFFFFF, 9,  1, 4'b1000, 32'h0,        32'h103,      32'hFFFFFF80, 1, 1);
        vecs[8]  = mk(1, 1, RES_LOAD, 0, 1, F3_BU, 32'h101,      32'h0,        32'h00009A00, 10, 1, 4'b0010, 32'h0,        32'h101,      32'h0000009A, 1, 1);
        vecs[9]  = mk(1, 1, RES_LOAD, 0, 1, F3_H,  32'h102,      32'h0,        32'h80010000, 11, 1, 4'b1100, 32'h0,        32'h102,      32'hFFFF8001, 1, 1);
        vecs[10] = mk(1, 1, RES_LOAD, 0, 1, F3_HU, 32'h100,      32'h0,        32'h1234F00D, 12, 1, 4'b0011, 32'h0,        32'h100,      32'h0000F00D, 1, 1);
        vecs[11] = mk(1, 1, RES_LOAD, 0, 1, F3_W,  32'h104,      32'h0,        32'h89ABCDEF, 13, 1, 4'b1111, 32'h0,        32'h104,      32'h89ABCDEF, 1, 1);

        // Reset state
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst_req", dbus_req, 0);
        chk("rst_stall", stall_m, 0);
        chk("rst_valid_w", valid_w, 0);
        chk("rst_regw_w", reg_write_w, 0);

        // Single accesses: zero-wait grant, response one cycle later
        foreach (vecs[i]) begin
            v = vecs[i];
            drive_op(v.rw, v.res, v.mw, v.mr, v.f3, v.addr, v.wdata, v.rd);
            valid_m = v.valid;
            dbus_gnt = v.exp_req;
            #1;
            chk($sformatf("v%0d_req", i), dbus_req, v.exp_req);
            chk($sformatf("v%0d_stall", i), stall_m, v.exp_req);
            if (v.exp_req) begin
                chk($sformatf("v%0d_be", i), dbus_be, v.exp_be);
                chk($sformatf("v%0d_addr", i), dbus_addr, v.exp_addr);
                if (v.mw) chk($sformatf("v%0d_wdata", i), dbus_wdata, v.exp_wdata);
            end
            step();
            if (v.exp_req) begin
                dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = v.rdata;
                #1;
                chk($sformatf("v%0d_resp_req", i), dbus_req, 0);
                chk($sformatf("v%0d_resp_stall", i), stall_m, 0);
                step();
                dbus_rvalid = 0;
            end
            chk($sformatf("v%0d_valid_w", i), valid_w, v.exp_valid_w);
            chk($sformatf("v%0d_regw_w", i), reg_write_w, v.exp_regw);
            if (v.exp_valid_w) begin
                chk($sformatf("v%0d_alu_w", i), alu_result_w, v.addr);
                chk($sformatf("v%0d_rd_w", i), rd_w, v.rd);
            end
            if (v.mr) chk($sformatf("v%0d_rdata_w", i), read_data_w, v.exp_rdata);
        end
        idle_inputs();
        step();

        // Store halfword with grant after three wait cycles; fields stable
        drive_op(0, RES_ALU, 1, 0, F3_H, 32'h202, 32'h1234, 0);
        for (int k = 0; k < 4; k++) begin
            dbus_gnt = (k == 3);
            #1;
            chk($sformatf("sh_req%0d", k), dbus_req, 1);
            chk($sformatf("sh_we%0d", k), dbus_we, 1);
            chk($sformatf("sh_addr%0d", k), dbus_addr, 32'h202);
            chk($sformatf("sh_wdata%0d", k), dbus_wdata, 32'h12341234);
            chk($sformatf("sh_be%0d", k), dbus_be, 4'b1100);
            chk($sformatf("sh_valid_w%0d", k), valid_w, 0);
            step();
        end
        dbus_gnt = 0;
        #1;
        chk("sh_resp_req", dbus_req, 0);
        chk("sh_resp_stall", stall_m, 1);
        step();
        dbus_rvalid = 1;
        #1;
        chk("sh_done_stall", stall_m, 0);
        step();
        chk("sh_valid_w", valid_w, 1);
        chk("sh_regw_w", reg_write_w, 0);
        idle_inputs();
        step();

        // Load never granted: abort after the timeout budget
        drive_op(1, RES_LOAD, 0, 1, F3_W, 32'h400, 0, 6);
        found = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall_m) begin
                found = k;
                break;
            end
            step();
        end
        if (found >= 0) step();
        chk("to_cycle", found, 16);
        chk("to_valid_w", valid_w, 1);
        chk("to_err_w", bus_err_w, 1);
        chk("to_regw_w", reg_write_w, 0);
        idle_inputs();
        #1;
        chk("to_stall_after", stall_m, 0);
        step();

        // Response carrying a bus error
        drive_op(1, RES_LOAD, 0, 1, F3_W, 32'h600, 0, 8);
        dbus_gnt = 1;
        step();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_err = 1; dbus_rdata = 32'h55AA55AA;
        step();
        chk("err_valid_w", valid_w, 1);
        chk("err_err_w", bus_err_w, 1);
        chk("err_regw_w", reg_write_w, 0);
        idle_inputs();
        step();

        // Reset while waiting for a response, then a stray response
        drive_op(1, RES_LOAD, 0, 1, F3_W, 32'h500, 0, 4);
        dbus_gnt = 1;
        step();
        dbus_gnt = 0;
        #1;
        chk("mid_stall", stall_m, 1);
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        chk("mrst_req", dbus_req, 0);
        chk("mrst_stall", stall_m, 0);
        chk("mrst_valid_w", valid_w, 0);
        chk("mrst_regw_w", reg_write_w, 0);
        chk("mrst_res_w", result_src_w, 0);
        chk("mrst_alu_w", alu_result_w, 0);
        chk("mrst_rdata_w", read_data_w, 0);
        chk("mrst_rd_w", rd_w, 0);
        chk("mrst_pc4_w", pc_plus_4w, 0);
        chk("mrst_err_w", bus_err_w, 0);
        chk("mrst_mis_w", misalign_w, 0);
        dbus_rvalid = 1; dbus_gnt = 1; dbus_rdata = 32'hFFFFFFFF;
        #1;
        chk("stray_req", dbus_req, 0);
        chk("stray_stall", stall_m, 0);
        step();
        chk("stray_valid_w", valid_w, 0);
        chk("stray_err_w", bus_err_w, 0);
        idle_inputs();
        drive_op(1, RES_ALU, 0, 0, F3_W, 32'h77, 0, 3);
        step();
        chk("post_valid_w", valid_w, 1);
        chk("post_alu_w", alu_result_w, 32'h77);
        idle_inputs();
        step();

        // Misaligned word load
        drive_op(1, RES_LOAD, 0, 1, F3_W, 32'h102, 0, 14);
`ifdef RISCV_MEM_MISALIGN_CHK_EN
        #1;
        chk("mis_req", dbus_req, 0);
        chk("mis_stall", stall_m, 0);
        step();
        chk("mis_valid_w", valid_w, 1);
        chk("mis_flag_w", misalign_w, 1);
        chk("mis_regw_w", reg_write_w, 0);
`else
        dbus_gnt = 1;
        #1;
        chk("mis_req", dbus_req, 1);
        chk("mis_addr", dbus_addr, 32'h100);
        step();
        dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h11223344;
        step();
        chk("mis_valid_w", valid_w, 1);
        chk("mis_flag_w", misalign_w, 0);
        chk("mis_regw_w", reg_write_w, 1);
        chk("mis_rdata_w", read_data_w, 32'h11223344);
`endif
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
